// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, DM priority.
// Optional IF anti-starvation counter enabled by defining ARB_STARVE_EN.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = $clog2(MEM_LAT) + 1;

  state_t        state;
  logic [CW-1:0] waitCnt;
  logic          ownerDm;
  logic          weQ;
  logic          ifRvalidQ;
  logic          dmRvalidQ;
  logic          arbIdle;
  logic          ifForce;
  logic          dmGrant;
  logic          ifGrant;

  // Gating with rst_n keeps the combinational grants low while reset is held.
  assign arbIdle = (state == IDLE) && rst_n;

`ifdef ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starveCnt;

  assign ifForce = if_req && (starveCnt == SW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
    end else if (ifGrant) begin
      starveCnt <= '0;
    end else if (dmGrant && if_req && (starveCnt != SW'(STARVE_MAX))) begin
      starveCnt <= starveCnt + SW'(1);
    end
  end
`else
  assign ifForce = 1'b0;
`endif

  assign dmGrant = arbIdle && dm_req && !ifForce;
  assign ifGrant = arbIdle && if_req && !dmGrant;
  assign dm_gnt  = dmGrant;
  assign if_gnt  = ifGrant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      waitCnt   <= '0;
      ownerDm   <= 1'b0;
      weQ       <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ifRvalidQ <= 1'b0;
      dmRvalidQ <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      ifRvalidQ <= 1'b0;
      dmRvalidQ <= 1'b0;
      case (state)
        IDLE: begin
          if (dmGrant) begin
            ownerDm   <= 1'b1;
            weQ       <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            state     <= ISSUE;
          end else if (ifGrant) begin
            ownerDm  <= 1'b0;
            weQ      <= 1'b0;
            mem_addr <= if_addr;
            mem_en   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_LAT == 1) begin
            ifRvalidQ <= !ownerDm;
            dmRvalidQ <= ownerDm;
            state     <= RESP;
          end else begin
            waitCnt <= CW'(MEM_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (waitCnt <= CW'(1)) begin
            ifRvalidQ <= !ownerDm;
            dmRvalidQ <= ownerDm;
            state     <= RESP;
          end else begin
            waitCnt <= waitCnt - CW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign if_rvalid = ifRvalidQ;
  assign dm_rvalid = dmRvalidQ;
  assign if_rdata  = ifRvalidQ ? mem_rdata : '0;
  assign dm_rdata  = (dmRvalidQ && !weQ) ? mem_rdata : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at MEM_LAT 1, 2 and 4.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifReq    [3];
  logic [15:0] ifAddr   [3];
  logic        ifGnt    [3];
  logic        ifRvalid [3];
  logic [31:0] ifRdata  [3];
  logic        dmReq    [3];
  logic        dmWe     [3];
  logic [15:0] dmAddr   [3];
  logic [31:0] dmWdata  [3];
  logic        dmGnt    [3];
  logic        dmRvalid [3];
  logic [31:0] dmRdata  [3];
  logic        memEn    [3];
  logic        memWe    [3];
  logic [15:0] memAddr  [3];
  logic [31:0] memWdata [3];
  logic [31:0] memRdata [3];
  logic        busy     [3];

  int nChecks;
  int nErrors;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    mem_port_arbiter #(.AW(16), .MEM_LAT(LAT), .STARVE_MAX(3)) u (
      .clk(clk), .rst_n(rst_n),
      .if_req(ifReq[g]), .if_addr(ifAddr[g]), .if_gnt(ifGnt[g]),
      .if_rvalid(ifRvalid[g]), .if_rdata(ifRdata[g]),
      .dm_req(dmReq[g]), .dm_we(dmWe[g]), .dm_addr(dmAddr[g]), .dm_wdata(dmWdata[g]),
      .dm_gnt(dmGnt[g]), .dm_rvalid(dmRvalid[g]), .dm_rdata(dmRdata[g]),
      .mem_en(memEn[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]),
      .mem_wdata(memWdata[g]), .mem_rdata(memRdata[g]), .busy(busy[g])
    );
    // Memory stand-in: data is a fixed function of the held address.
    assign memRdata[g] = 32'hC0DE_0000 | {16'h0000, memAddr[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic waitIdle(input int k);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy[k]) begin
        done = 1'b1;
        break;
      end
      nxt();
    end
    chk("idleTimeout", {31'd0, done}, 32'd1);
  endtask

  int          n;
  int          lastC;
  int          ifWhileDm;
  int          hits;
  logic [7:0]  seq;
  logic [9:0]  gntPat;
  logic [9:0]  rvPat;

  initial begin
    nChecks = 0;
    nErrors = 0;
    rst_n   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ifReq[k] = 1'b0; ifAddr[k] = '0;
      dmReq[k] = 1'b0; dmWe[k] = 1'b0; dmAddr[k] = '0; dmWdata[k] = '0;
    end
    ifReq[1] = 1'b1;
    nxt(); nxt();
    chk("rstIfGnt", {31'd0, ifGnt[1]}, 32'd0);
    chk("rstBusy", {31'd0, busy[1]}, 32'd0);
    chk("rstMemEn", {31'd0, memEn[1]}, 32'd0);
    chk("rstMemAddr", {16'd0, memAddr[1]}, 32'd0);
    ifReq[1] = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();

    // IF read, MEM_LAT=2
    ifReq[1] = 1'b1; ifAddr[1] = 16'h0040; #1;
    chk("rdIfGnt", {31'd0, ifGnt[1]}, 32'd1);
    chk("rdDmGnt", {31'd0, dmGnt[1]}, 32'd0);
    nxt(); ifReq[1] = 1'b0; #1;
    chk("rdMemEn", {31'd0, memEn[1]}, 32'd1);
    chk("rdMemAddr", {16'd0, memAddr[1]}, 32'h0040);
    chk("rdMemWe", {31'd0, memWe[1]}, 32'd0);
    chk("rdBusy", {31'd0, busy[1]}, 32'd1);
    nxt();
    chk("rdMemEnOff", {31'd0, memEn[1]}, 32'd0);
    chk("rdEarlyRv", {31'd0, ifRvalid[1]}, 32'd0);
    nxt();
    chk("rdRvalid", {31'd0, ifRvalid[1]}, 32'd1);
    chk("rdRdata", ifRdata[1], 32'hC0DE0040);
    nxt();
    chk("rdRvOff", {31'd0, ifRvalid[1]}, 32'd0);
    chk("rdRdataOff", ifRdata[1], 32'd0);
    chk("rdIdle", {31'd0, busy[1]}, 32'd0);

    // Contention: DM write beats IF read
    ifReq[1] = 1'b1; ifAddr[1] = 16'h0080;
    dmReq[1] = 1'b1; dmWe[1] = 1'b1; dmAddr[1] = 16'h0100; dmWdata[1] = 32'hDEADBEEF; #1;
    chk("ctDmGnt", {31'd0, dmGnt[1]}, 32'd1);
    chk("ctIfGnt", {31'd0, ifGnt[1]}, 32'd0);
    nxt(); dmReq[1] = 1'b0; #1;
    chk("ctMemEn", {31'd0, memEn[1]}, 32'd1);
    chk("ctMemWe", {31'd0, memWe[1]}, 32'd1);
    chk("ctMemAddr", {16'd0, memAddr[1]}, 32'h0100);
    chk("ctMemWdata", memWdata[1], 32'hDEADBEEF);
    chk("ctIfHeld", {31'd0, ifGnt[1]}, 32'd0);
    nxt(); nxt();
    chk("ctDmRvalid", {31'd0, dmRvalid[1]}, 32'd1);
    chk("ctDmRdata", dmRdata[1], 32'd0);
    chk("ctIfRvalid", {31'd0, ifRvalid[1]}, 32'd0);
    nxt();
    chk("ctIfGnt2", {31'd0, ifGnt[1]}, 32'd1);
    chk("ctDmGnt2", {31'd0, dmGnt[1]}, 32'd0);
    nxt(); ifReq[1] = 1'b0; #1;
    chk("ctIfMemAddr", {16'd0, memAddr[1]}, 32'h0080);
    chk("ctIfMemWe", {31'd0, memWe[1]}, 32'd0);
    nxt(); nxt();
    chk("ctIfRv", {31'd0, ifRvalid[1]}, 32'd1);
    chk("ctIfRdata", ifRdata[1], 32'hC0DE0080);
    chk("ctDmRvOff", {31'd0, dmRvalid[1]}, 32'd0);
    waitIdle(1);

    // LAT=4 read timing, then reset during WAIT
    ifReq[2] = 1'b1; ifAddr[2] = 16'h0300; #1;
    chk("l4Gnt", {31'd0, ifGnt[2]}, 32'd1);
    nxt(); ifReq[2] = 1'b0; #1;
    chk("l4MemEn", {31'd0, memEn[2]}, 32'd1);
    nxt(); nxt(); nxt();
    chk("l4EarlyRv", {31'd0, ifRvalid[2]}, 32'd0);
    nxt();
    chk("l4Rvalid", {31'd0, ifRvalid[2]}, 32'd1);
    chk("l4Rdata", ifRdata[2], 32'hC0DE0300);
    waitIdle(2);
    ifReq[2] = 1'b1; ifAddr[2] = 16'h0304; #1;
    nxt(); ifReq[2] = 1'b0;
    nxt();
    rst_n = 1'b0; #1;
    chk("mrBusy", {31'd0, busy[2]}, 32'd0);
    chk("mrMemAddr", {16'd0, memAddr[2]}, 32'd0);
    chk("mrMemEn", {31'd0, memEn[2]}, 32'd0);
    chk("mrRvalid", {31'd0, ifRvalid[2]}, 32'd0);
    chk("mrRdata", ifRdata[2], 32'd0);
    nxt();
    rst_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      nxt();
      if (ifRvalid[2] || dmRvalid[2] || memEn[2] || busy[2]) hits++;
    end
    chk("mrQuiet", hits, 32'd0);

    // Starvation: both requests held on the LAT=2 instance
    ifReq[1] = 1'b1; ifAddr[1] = 16'h0084;
    dmReq[1] = 1'b1; dmWe[1] = 1'b0; dmAddr[1] = 16'h0200;
    seq = '0; n = 0; lastC = -1; ifWhileDm = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      #1;
      if (ifGnt[1] && dmReq[1]) ifWhileDm++;
      if (dmGnt[1]) begin
        seq[n] = 1'b1; n++; lastC = c;
      end else if (ifGnt[1]) begin
        n++; lastC = c;
      end
      @(negedge clk);
    end
    #1;
    ifReq[1] = 1'b0; dmReq[1] = 1'b0;
    chk("svCount", n, 32'd8);
    chk("svSpacing", lastC, 32'd28);
`ifdef ARB_STARVE_EN
    chk("svOrder", {24'd0, seq}, 32'h77);
    chk("svIfForced", ifWhileDm, 32'd2);
`else
    chk("svOrder", {24'd0, seq}, 32'hFF);
    chk("svIfForced", ifWhileDm, 32'd0);
`endif
    waitIdle(1);

    // Back-to-back IF reads, MEM_LAT=1
    nxt();
    ifReq[0] = 1'b1; ifAddr[0] = 16'h0010;
    gntPat = '0; rvPat = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      gntPat[c] = ifGnt[0];
      rvPat[c]  = ifRvalid[0];
      @(negedge clk);
    end
    #1;
    ifReq[0] = 1'b0;
    chk("b2bGnt", {22'd0, gntPat}, 32'h249);
    chk("b2bRv", {22'd0, rvPat}, 32'h124);
    waitIdle(0);

    // Single-cycle IF pulse while busy is ignored
    ifReq[0] = 1'b1; ifAddr[0] = 16'h0020; #1;
    nxt(); ifReq[0] = 1'b0;
    nxt(); ifReq[0] = 1'b1; #1;
    chk("plsGntBusy", {31'd0, ifGnt[0]}, 32'd0);
    nxt(); ifReq[0] = 1'b0; #1;
    chk("plsGntIdle", {31'd0, ifGnt[0]}, 32'd0);
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      nxt();
      if (memEn[0] || busy[0]) hits++;
    end
    chk("plsNoAccess", hits, 32'd0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
